// File: rtl/iter_sequencer_if.sv
// Iteration sequencer control bundle.
// Carries the run controls (enb, start, length, mode, abort) from the datapath controller to the
// sequencer, and the status/flag outputs (busy, count, flag_first, flag_last, wrap, done,
// err_len) back to it.
//   master : controller side, drives the controls and observes the status
//   slave  : sequencer side, observes the controls and drives the status
interface iter_sequencer_if #(
  parameter int unsigned CNT_WIDTH = 16
) ();

  logic                 enb;
  logic                 start;
  logic [CNT_WIDTH-1:0] length;
  logic                 mode;
  logic                 abort;
  logic                 busy;
  logic [CNT_WIDTH-1:0] count;
  logic                 flag_first;
  logic                 flag_last;
  logic                 wrap;
  logic                 done;
  logic                 err_len;

  modport master (
    output enb,
    output start,
    output length,
    output mode,
    output abort,
    input  busy,
    input  count,
    input  flag_first,
    input  flag_last,
    input  wrap,
    input  done,
    input  err_len
  );

  modport slave (
    input  enb,
    input  start,
    input  length,
    input  mode,
    input  abort,
    output busy,
    output count,
    output flag_first,
    output flag_last,
    output wrap,
    output done,
    output err_len
  );

endinterface

// File: rtl/iter_sequencer.sv
// Run-time programmable iteration sequencer for multicycle arithmetic datapaths.
// Counts a latched number of iterations N under a start/busy/done handshake with a stall enable,
// and flags the first FIRST_CYCLES iterations (feedback mux select) and the last iteration.
// Single-pass mode ends with a one-cycle DONE state; continuous mode wraps back to count 0.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous reset, active high
//   bus  : slave side of iter_sequencer_if (controls in, status/flags out)
module iter_sequencer #(
  parameter int unsigned CNT_WIDTH    = 16,
  parameter int unsigned FIRST_CYCLES = 2
) (
  input logic             clk,
  input logic             rst,
  iter_sequencer_if.slave bus
);

  localparam logic [CNT_WIDTH-1:0] One         = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] FirstCycles = CNT_WIDTH'(FIRST_CYCLES);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic [CNT_WIDTH-1:0] len_q, len_d;
  logic                 wrap_q, wrap_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic                 at_last;

  // len_q is never 0 while in RUN, so len_q - 1 cannot underflow there.
  assign at_last = (count_q == (len_q - One));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      count_q <= '0;
      len_q   <= '0;
      wrap_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      len_q   <= len_d;
      wrap_q  <= wrap_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    len_d   = len_q;
    wrap_d  = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;

    if (bus.abort) begin
      // Abort wins over any transition and swallows a same-cycle err_len.
      state_d = StIdle;
      count_d = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          count_d = '0;
          // Start is accepted in IDLE even while stalled.
          if (bus.start) begin
            if (bus.length != '0) begin
              len_d   = bus.length;
              state_d = StRun;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        StRun: begin
          if (bus.enb) begin
            if (!at_last) begin
              count_d = count_q + One;
            end else if (bus.mode) begin
              count_d = '0;
              wrap_d  = 1'b1;
            end else begin
              // count holds N-1 through DONE
              state_d = StDone;
              done_d  = 1'b1;
            end
          end
        end
        StDone: begin
          state_d = StIdle;
          count_d = '0;
        end
        default: begin
          state_d = StIdle;
          count_d = '0;
        end
      endcase
    end
  end

  assign bus.busy       = (state_q == StRun);
  assign bus.count      = count_q;
  assign bus.flag_first = bus.busy & (count_q < FirstCycles);
  assign bus.flag_last  = bus.busy & at_last;
  assign bus.wrap       = wrap_q;
  assign bus.done       = done_q;
  assign bus.err_len    = err_q;

endmodule
